// File: rtl/crc16_checker.sv
// Receive-side CRC16 frame checker: recomputes the CRC over each frame's data words,
// compares it against the trailing CRC word, and keeps saturating good/bad frame counters.
module crc16_checker #(
    parameter logic [15:0] POLY      = 16'h1021,
    parameter logic [15:0] INIT      = 16'h0000,
    parameter int          MAX_WORDS = 64,
    parameter int          CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_din_valid,
    input  logic [15:0]      i_din,
    input  logic             i_din_last,
    input  logic             i_stat_clr,
    output logic             o_dout_valid,
    output logic [15:0]      o_dout,
    output logic             o_crc_ok,
    output logic             o_len_err,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_good_cnt,
    output logic [CNT_W-1:0] o_bad_cnt
);

    localparam int WC_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_OVF  = 2'd2
    } state_t;

    // Sixteen MSB-first serial steps of the LFSR collapsed into one word update.
    function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end
        return c;
    endfunction

    state_t            r_state;
    logic [15:0]       r_crc;
    logic [WC_W-1:0]   r_word_cnt;
    logic              r_dout_valid;
    logic [15:0]       r_dout;
    logic              r_crc_ok;
    logic              r_len_err;
    logic              r_busy;
    logic [CNT_W-1:0]  r_good_cnt;
    logic [CNT_W-1:0]  r_bad_cnt;

    logic              w_fin;
    logic [15:0]       w_calc;
    logic              w_len;
    logic              w_ok;

    // Result of the frame that ends with this cycle's last word.
    always_comb begin
        w_fin  = i_din_valid & i_din_last;
        w_len  = 1'b0;
        w_calc = INIT;
        case (r_state)
            ST_IDLE: begin
                w_calc = INIT;
                w_len  = 1'b0;
            end
            ST_DATA: begin
                w_calc = r_crc;
                w_len  = 1'b0;
            end
            ST_OVF: begin
                w_calc = r_crc;
                w_len  = 1'b1;
            end
            default: begin
                w_calc = INIT;
                w_len  = 1'b0;
            end
        endcase
        w_ok = (i_din == w_calc) & ~w_len;
    end

    // Frame FSM, running CRC and registered result outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_crc        <= INIT;
            r_word_cnt   <= '0;
            r_dout_valid <= 1'b0;
            r_dout       <= 16'h0000;
            r_crc_ok     <= 1'b0;
            r_len_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            if (w_fin) begin
                r_dout_valid <= 1'b1;
                r_dout       <= w_calc;
                r_crc_ok     <= w_ok;
                r_len_err    <= w_len;
                r_state      <= ST_IDLE;
                r_busy       <= 1'b0;
                r_crc        <= INIT;
                r_word_cnt   <= '0;
            end else if (i_din_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        r_crc      <= crc_upd(INIT, i_din);
                        r_word_cnt <= WC_W'(1);
                        r_state    <= ST_DATA;
                        r_busy     <= 1'b1;
                    end
                    ST_DATA: begin
                        // Overflowing word is dropped so r_crc keeps the CRC of the first MAX_WORDS.
                        if (r_word_cnt == WC_W'(MAX_WORDS)) begin
                            r_state <= ST_OVF;
                        end else begin
                            r_crc      <= crc_upd(r_crc, i_din);
                            r_word_cnt <= r_word_cnt + WC_W'(1);
                        end
                    end
                    ST_OVF: begin
                        r_state <= ST_OVF;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating frame statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (i_stat_clr) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (w_fin) begin
            if (w_ok) begin
                if (r_good_cnt != '1) begin
                    r_good_cnt <= r_good_cnt + CNT_W'(1);
                end
            end else begin
                if (r_bad_cnt != '1) begin
                    r_bad_cnt <= r_bad_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_dout_valid = r_dout_valid;
    assign o_dout       = r_dout;
    assign o_crc_ok     = r_crc_ok;
    assign o_len_err    = r_len_err;
    assign o_busy       = r_busy;
    assign o_good_cnt   = r_good_cnt;
    assign o_bad_cnt    = r_bad_cnt;

endmodule

// File: tb/tb_crc16_checker.sv
// Self-checking bench for crc16_checker: directed frames plus randomized traffic,
// with expected results from a polynomial-division CRC model and a result scoreboard.
module tb_crc16_checker;

    localparam int          MAXW = 4;
    localparam int          CW   = 4;
    localparam int          SAT  = (1 << CW) - 1;
    localparam logic [15:0] POLY = 16'h1021;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_din_valid;
    logic [15:0]   i_din;
    logic          i_din_last;
    logic          i_stat_clr;
    logic          o_dout_valid;
    logic [15:0]   o_dout;
    logic          o_crc_ok;
    logic          o_len_err;
    logic          o_busy;
    logic [CW-1:0] o_good_cnt;
    logic [CW-1:0] o_bad_cnt;

    crc16_checker #(
        .POLY(POLY), .INIT(16'h0000), .MAX_WORDS(MAXW), .CNT_W(CW)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_din_valid(i_din_valid), .i_din(i_din),
        .i_din_last(i_din_last), .i_stat_clr(i_stat_clr), .o_dout_valid(o_dout_valid),
        .o_dout(o_dout), .o_crc_ok(o_crc_ok), .o_len_err(o_len_err), .o_busy(o_busy),
        .o_good_cnt(o_good_cnt), .o_bad_cnt(o_bad_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [15:0]   dout;
        logic          ok;
        logic          len;
        logic [CW-1:0] good;
        logic [CW-1:0] bad;
    } res_t;

    res_t exp_q[$];
    res_t held;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   n_pulses   = 0;
    int   n_expected = 0;
    int   m_good     = 0;
    int   m_bad      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CRC as remainder of M(x)*x^16 divided by the generator (INIT = 0, no final XOR).
    function automatic logic [15:0] ref_crc(input logic [15:0] w[$], input int n);
        bit          m[$];
        logic [16:0] g;
        logic [15:0] r;
        g = {1'b1, POLY};
        for (int k = 0; k < n; k++)
            for (int b = 15; b >= 0; b--) m.push_back(w[k][b]);
        for (int b = 0; b < 16; b++) m.push_back(1'b0);
        for (int i = 0; i + 16 < m.size(); i++)
            if (m[i])
                for (int j = 0; j < 17; j++) m[i+j] = m[i+j] ^ g[16-j];
        r = 16'h0000;
        for (int b = 0; b < 16; b++) r[15-b] = m[m.size()-16+b];
        return r;
    endfunction

    task automatic send(input logic v, input logic [15:0] d, input logic l, input logic clr);
        i_din_valid = v;
        i_din       = d;
        i_din_last  = l;
        i_stat_clr  = clr;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, 16'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic run_frame(input logic [15:0] w[$], input logic [15:0] rx,
                             input int gap_at, input int gaps, input logic clr);
        res_t e;
        int   n;
        int   used;
        n = w.size();
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) idle(gaps);
            send(1'b1, w[k], 1'b0, 1'b0);
            if (k == 0) check_eq("busy_in_frame", 32'(o_busy), 32'd1);
        end
        used   = (n > MAXW) ? MAXW : n;
        e.dout = ref_crc(w, used);
        e.len  = (n > MAXW);
        e.ok   = !e.len && (rx == e.dout);
        if (clr) begin
            m_good = 0;
            m_bad  = 0;
        end else if (e.ok) begin
            m_good = (m_good >= SAT) ? SAT : m_good + 1;
        end else begin
            m_bad = (m_bad >= SAT) ? SAT : m_bad + 1;
        end
        e.good = CW'(m_good);
        e.bad  = CW'(m_bad);
        exp_q.push_back(e);
        n_expected++;
        send(1'b1, rx, 1'b1, clr);
        check_eq("busy_after_last", 32'(o_busy), 32'd0);
    endtask

    // Scoreboard: every pulse must match the next expected result; outputs hold in between.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            held = '0;
        end else if (o_dout_valid) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                held = exp_q.pop_front();
                check_eq("res_dout", 32'(o_dout), 32'(held.dout));
                check_eq("res_crc_ok", 32'(o_crc_ok), 32'(held.ok));
                check_eq("res_len_err", 32'(o_len_err), 32'(held.len));
                check_eq("res_good_cnt", 32'(o_good_cnt), 32'(held.good));
                check_eq("res_bad_cnt", 32'(o_bad_cnt), 32'(held.bad));
            end
        end else begin
            check_eq("hold_dout", 32'(o_dout), 32'(held.dout));
            check_eq("hold_crc_ok", 32'(o_crc_ok), 32'(held.ok));
            check_eq("hold_len_err", 32'(o_len_err), 32'(held.len));
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(o_dout_valid), 32'd0);
        check_eq({tag, "_dout"}, 32'(o_dout), 32'd0);
        check_eq({tag, "_ok"}, 32'(o_crc_ok), 32'd0);
        check_eq({tag, "_len"}, 32'(o_len_err), 32'd0);
        check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
        check_eq({tag, "_good"}, 32'(o_good_cnt), 32'd0);
        check_eq({tag, "_bad"}, 32'(o_bad_cnt), 32'd0);
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] c;
        logic [15:0] dout1;
        int          n;

        i_rst_n = 1'b0; i_din_valid = 1'b0; i_din = 16'h0000; i_din_last = 1'b0; i_stat_clr = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Known vector: {0x8000} -> 0x1B98
        q = '{16'h8000};
        run_frame(q, 16'h1B98, -1, 0, 1'b0);
        check_eq("known_valid", 32'(o_dout_valid), 32'd1);
        check_eq("known_dout", 32'(o_dout), 32'h1B98);
        check_eq("known_ok", 32'(o_crc_ok), 32'd1);
        check_eq("known_good", 32'(o_good_cnt), 32'd1);
        idle(1);
        check_eq("pulse_one_cycle", 32'(o_dout_valid), 32'd0);

        run_frame(q, 16'h1B99, -1, 0, 1'b0);
        check_eq("bad_crc_dout", 32'(o_dout), 32'h1B98);
        check_eq("bad_crc_ok", 32'(o_crc_ok), 32'd0);
        check_eq("bad_crc_cnt", 32'(o_bad_cnt), 32'd1);
        idle(2);

        // Zero-length frames
        q.delete();
        run_frame(q, 16'h0000, -1, 0, 1'b0);
        check_eq("zero_len_ok", 32'(o_crc_ok), 32'd1);
        check_eq("zero_len_dout", 32'(o_dout), 32'd0);
        run_frame(q, 16'h1234, -1, 0, 1'b0);
        check_eq("zero_len_bad", 32'(o_crc_ok), 32'd0);
        idle(1);

        // Back-to-back, second frame with a mid-frame gap
        q = '{16'h8000, 16'h0000};
        c = ref_crc(q, 2);
        run_frame(q, c, -1, 0, 1'b0);
        dout1 = o_dout;
        run_frame(q, c, 1, 3, 1'b0);
        check_eq("b2b_same_dout", 32'(o_dout), 32'(dout1));
        check_eq("b2b_ok", 32'(o_crc_ok), 32'd1);
        idle(1);
        check_eq("b2b_pulse_end", 32'(o_dout_valid), 32'd0);

        // Length overflow: 6 data words with MAX_WORDS = 4
        q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        c = ref_crc(q, 4);
        run_frame(q, c, -1, 0, 1'b0);
        check_eq("ovf_len_err", 32'(o_len_err), 32'd1);
        check_eq("ovf_ok", 32'(o_crc_ok), 32'd0);
        idle(2);

        // Reset in mid-frame discards the frame
        send(1'b1, 16'hAAAA, 1'b0, 1'b0);
        send(1'b1, 16'h5555, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        i_din_valid = 1'b0;
        #2;
        check_all_zero("midreset");
        m_good = 0;
        m_bad  = 0;
        @(posedge i_clk);
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        q = '{16'hABCD, 16'h0001};
        run_frame(q, ref_crc(q, 2), -1, 0, 1'b0);
        check_eq("after_reset_good", 32'(o_good_cnt), 32'd1);
        run_frame(q, ref_crc(q, 2), -1, 0, 1'b1);
        check_eq("clr_good", 32'(o_good_cnt), 32'd0);
        check_eq("clr_bad", 32'(o_bad_cnt), 32'd0);
        idle(1);

        // Counter saturation
        q.delete();
        for (int k = 0; k < SAT + 4; k++) run_frame(q, 16'h0000, -1, 0, 1'b0);
        check_eq("good_saturated", 32'(o_good_cnt), 32'(SAT));
        for (int k = 0; k < SAT + 4; k++) run_frame(q, 16'hBEEF, -1, 0, 1'b0);
        check_eq("bad_saturated", 32'(o_bad_cnt), 32'(SAT));
        idle(1);
        send(1'b0, 16'h0000, 1'b0, 1'b1);
        m_good = 0;
        m_bad  = 0;
        check_eq("idle_clr_good", 32'(o_good_cnt), 32'd0);

        // Randomized traffic
        for (int f = 0; f < 60; f++) begin
            n = $urandom_range(0, 6);
            q.delete();
            for (int k = 0; k < n; k++) q.push_back(16'($urandom));
            if ($urandom_range(0, 1) == 1) c = ref_crc(q, (n > MAXW) ? MAXW : n);
            else c = 16'($urandom);
            run_frame(q, c, (n > 0) ? $urandom_range(0, n - 1) : -1, $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0));
            idle($urandom_range(0, 2));
        end

        idle(3);
        check_eq("pulse_count", 32'(n_pulses), 32'(n_expected));
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
